ins_fetch32: RTL
================

# ins_fetch32

Instruction fetch sequencer for the 32-bit MIPS datapath. It owns the program counter, drives the address into the combinational instruction memory, and captures each returned word together with its PC into a small prefetch FIFO. It presents instructions to the decode stage over a valid/ready handshake. A redirect input flushes the FIFO and reloads the PC for branches and jumps.

## Interface
- `AW`, default 4: instruction address width (words); PC wraps modulo 2^AW.
- `DW`, default 32: instruction width.
- `DEPTH`, default 2: prefetch FIFO entries (power of two, ≥2).
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `fetch_en`, in, 1: fetching permitted; low stalls the PC but the FIFO still drains.
- `ins_add`, out, AW: word address to instruction memory; equals `pc` register.
- `ins_dec`, in, DW: instruction word from memory; combinational on `ins_add`, valid the same cycle.
- `redir_valid`, in, 1: redirect request, one-cycle pulse.
- `redir_pc`, in, AW: redirect target.
- `out_valid`, out, 1: head FIFO entry valid.
- `out_ready`, in, 1: decode accepts head entry.
- `out_ins`, out, DW: head instruction.
- `out_pc`, out, AW: address of head instruction.
- `fifo_count`, out, clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- State: `pc`, FIFO storage {pc, ins} × DEPTH, read/write pointers, count.
- Pop condition: `pop = out_valid & out_ready`.
- Push condition: `push = fetch_en & !redir_valid & (count < DEPTH | pop)`.
  - Push writes {pc, ins_dec} at the write pointer.
  - `pc <= pc + 1` mod 2^AW. 15 → 0 at AW=4; no error, no stall.
- Simultaneous push and pop: allowed at any count, including full. Count is unchanged and both pointers advance.
- Redirect (highest priority):
  - On a `redir_valid` cycle: count, read pointer and write pointer are cleared, `pc <= redir_pc`.
  - No push occurs that cycle. Any pop that cycle is discarded; the decode stage must treat the head as squashed.
- Redirect while `fetch_en` is low: the PC is still reloaded and the FIFO still flushed.
- `out_valid = (count != 0)`. `out_ins` and `out_pc` come from the head entry. They are don't-care when `out_valid` is low but must not be X after reset; storage resets to 0.
- Head stability: while `out_valid & !out_ready` and no redirect, `out_ins` and `out_pc` hold stable.
- Reset, including mid-operation: `pc=0`, count=0, pointers=0, storage=0. Outputs after reset: `ins_add=0`, `out_valid=0`, `out_ins=0`, `out_pc=0`, `fifo_count=0`.
  - `rst` overrides `redir_valid`.

## Timing
- Memory path is combinational: `ins_add` → `ins_dec` → FIFO write within one cycle.
- Fetch-to-output latency: 1 cycle. The address presented in cycle N appears at `out_valid`/`out_ins` in cycle N+1 if the FIFO was empty.
- Redirect latency:
  - Redirect asserted in cycle N → `ins_add = redir_pc` in cycle N+1.
  - `out_valid=1` with `out_pc = redir_pc` in cycle N+2.
  - `out_valid=0` in cycle N+1.
- Throughput: 1 instruction/cycle sustained with `out_ready` held high.
- With `out_ready` low, fetch stops after DEPTH pushes. The PC then holds at the next unfetched address.
- First fetch after reset release: `ins_add=0` in the first cycle with `rst` low; push at the end of that cycle if `fetch_en`=1.

## Test plan
- Bench memory model returns `ins_dec = 32'hA5A50000 | ins_add`.
- Streaming: reset, `fetch_en=1`, `out_ready=1`.
  - Required: `out_pc` = 0,1,2,… on consecutive cycles starting one cycle after reset release, with `out_ins=32'hA5A50000+pc`.
  - Required: after pc 15, `out_pc=0` (wrap).
- Backpressure: `out_ready=0` for 5 cycles.
  - Required: `fifo_count` reaches 2 and holds; `ins_add` holds at 2; `out_pc=0` stable throughout.
  - Then `out_ready=1`: required sequence 0,1,2,… with no gaps or duplicates.
- Full with simultaneous push/pop: FIFO full, `out_ready=1` for one cycle.
  - Required: count stays 2, `ins_add` advances by 1, head advances by 1.
- Redirect: assert `redir_valid=1`, `redir_pc=4'd9` while FIFO holds 2 entries and `out_ready=1`.
  - Required next cycle: `out_valid=0`, `fifo_count=0`, `ins_add=9`.
  - Required the cycle after: `out_pc=9`, `out_ins=32'hA5A50009`.
- Stall/redirect interaction: `fetch_en=0` with redirect to 3.
  - Required: PC reloads to 3, FIFO empty, no pushes while `fetch_en=0`.
  - Raise `fetch_en`: required that the first output is `out_pc=3`.
- Reset mid-stream: assert `rst` for 1 cycle while FIFO is full and `redir_valid=1`.
  - Required next cycle: all outputs zero, `ins_add=0`.

Source files
------------

// File: rtl/ins_fetch32.sv
// Instruction fetch sequencer: owns the PC, reads a combinational instruction
// memory and buffers {pc, ins} pairs in a small prefetch FIFO for decode.
module ins_fetch32 #(
  parameter int AW    = 4,
  parameter int DW    = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fetch_en,
  output logic [AW-1:0]              ins_add,
  input  logic [DW-1:0]              ins_dec,
  input  logic                       redir_valid,
  input  logic [AW-1:0]              redir_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DW-1:0]              out_ins,
  output logic [AW-1:0]              out_pc,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] r_pc;
  logic [DW-1:0] r_mem_ins [DEPTH];
  logic [AW-1:0] r_mem_pc  [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic w_pop;
  logic w_push;

  assign out_valid  = (r_count != '0);
  assign out_ins    = r_mem_ins[r_rd_ptr];
  assign out_pc     = r_mem_pc[r_rd_ptr];
  assign ins_add    = r_pc;
  assign fifo_count = r_count;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_pop  = out_valid & out_ready;
  assign w_push = fetch_en & ~redir_valid & ((r_count < CW'(DEPTH)) | w_pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      // NOTE: storage is reset so the head outputs are never X, even when
      // out_valid is low; this costs a reset on every FIFO entry.
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_ins[i] <= '0;
        r_mem_pc[i]  <= '0;
      end
    end else if (redir_valid) begin
      r_pc     <= redir_pc;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem_ins[r_wr_ptr] <= ins_dec;
        r_mem_pc[r_wr_ptr]  <= r_pc;
        r_wr_ptr            <= r_wr_ptr + 1'b1;
        r_pc                <= r_pc + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
